// File: rtl/rc4_cipher_buffer.sv
// rc4_cipher_buffer: captures one contiguous burst of RC4 ciphertext,
// holds it, and replays it (any number of times) under valid/ready flow
// control. Overflow and writes dropped during replay are reported as
// sticky flags. A flush discards the frame and returns to IDLE.
//
// Handshake: a read word transfers on each rising edge where
// rd_valid=1 and rd_ready=1; while rd_valid=1 and rd_ready=0, rd_valid,
// rd_data and rd_last hold stable. rd_valid never depends on rd_ready.
//
// o_dbg_state exposes the FSM: 0=IDLE, 1=CAPTURE, 2=HOLD, 3=REPLAY.
module rc4_cipher_buffer #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 256,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_start,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic [ADDR_W:0]   frame_len,
   output logic              busy,
   output logic              overflow,
   output logic              wr_drop,
   output logic [1:0]        o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_HOLD    = 2'd2,
      S_REPLAY  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

   state_t r_state;
   state_t w_state_nxt;

   // Frame storage; never cleared, only overwritten by a new capture.
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [ADDR_W:0]   r_count;
   logic [ADDR_W:0]   r_frame_len;
   logic [ADDR_W:0]   r_rd_ptr;
   logic              r_overflow;
   logic              r_wr_drop;

   // Two-stage read pipeline: r_pf is the synchronous memory read
   // (prefetch) register, r_rd_* is the presented output word.
   logic [DATA_W-1:0] r_pf;
   logic              r_pf_valid;
   logic              r_pf_last;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic              r_rd_last;

   logic              w_wr_en;
   logic [ADDR_W-1:0] w_wr_addr;
   logic              w_cap_start;
   logic              w_cap_end;
   logic              w_ovf_set;
   logic              w_drop_set;
   logic              w_rep_start;
   logic              w_rep_done;
   logic              w_xfer;
   logic              w_out_adv;
   logic              w_pf_take;
   logic              w_rd_en;

   assign w_xfer    = r_rd_valid & rd_ready;
   // Output stage may load when empty or when its word is being taken.
   assign w_out_adv = ~r_rd_valid | rd_ready;
   // Prefetch stage may be overwritten when empty or moving to output.
   assign w_pf_take = ~r_pf_valid | w_out_adv;
   assign w_rd_en   = (r_state == S_REPLAY) & w_pf_take & (r_rd_ptr < r_frame_len);

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and per-cycle control strobes; reset and flush win over everything.
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_wr_addr   = r_count[ADDR_W-1:0];
      w_cap_start = 1'b0;
      w_cap_end   = 1'b0;
      w_ovf_set   = 1'b0;
      w_drop_set  = 1'b0;
      w_rep_start = 1'b0;
      w_rep_done  = 1'b0;
      if (!rst || flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (wr_valid) begin
                  w_wr_en     = 1'b1;
                  w_wr_addr   = '0;
                  w_cap_start = 1'b1;
                  w_state_nxt = S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (wr_valid) begin
                  if (r_count < DEPTH_L) begin
                     w_wr_en = 1'b1;
                  end else begin
                     w_ovf_set = 1'b1;
                  end
               end else begin
                  w_cap_end   = 1'b1;
                  w_state_nxt = S_HOLD;
               end
            end
            S_HOLD: begin
               if (wr_valid) begin
                  w_wr_en     = 1'b1;
                  w_wr_addr   = '0;
                  w_cap_start = 1'b1;
                  w_state_nxt = S_CAPTURE;
               end else if (rd_start) begin
                  w_rep_start = 1'b1;
                  w_state_nxt = S_REPLAY;
               end
            end
            S_REPLAY: begin
               if (wr_valid) begin
                  w_drop_set = 1'b1;
               end
               if (w_xfer && r_rd_last) begin
                  w_rep_done  = 1'b1;
                  w_state_nxt = S_HOLD;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Frame memory write port and synchronous prefetch read.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= wr_data;
      end
      if (w_rd_en) begin
         r_pf <= r_mem[r_rd_ptr[ADDR_W-1:0]];
      end
   end

   // Counters, sticky flags and the read pipeline control.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count     <= '0;
         r_frame_len <= '0;
         r_rd_ptr    <= '0;
         r_overflow  <= 1'b0;
         r_wr_drop   <= 1'b0;
         r_pf_valid  <= 1'b0;
         r_pf_last   <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_last   <= 1'b0;
         r_rd_data   <= '0;
      end else if (flush) begin
         r_count     <= '0;
         r_frame_len <= '0;
         r_rd_ptr    <= '0;
         r_overflow  <= 1'b0;
         r_wr_drop   <= 1'b0;
         r_pf_valid  <= 1'b0;
         r_pf_last   <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_last   <= 1'b0;
      end else begin
         if (w_cap_start) begin
            r_count     <= ONE_L;
            r_frame_len <= '0;
            r_overflow  <= 1'b0;
            r_wr_drop   <= 1'b0;
         end else if (w_wr_en) begin
            r_count <= r_count + ONE_L;
         end
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end
         if (w_drop_set) begin
            r_wr_drop <= 1'b1;
         end
         if (w_cap_end) begin
            r_frame_len <= r_count;
         end
         if (w_rep_start) begin
            r_rd_ptr   <= '0;
            r_pf_valid <= 1'b0;
            r_pf_last  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
         end else if (r_state == S_REPLAY) begin
            if (w_rep_done) begin
               r_pf_valid <= 1'b0;
               r_rd_valid <= 1'b0;
               r_rd_last  <= 1'b0;
            end else begin
               if (w_out_adv) begin
                  r_rd_valid <= r_pf_valid;
                  r_rd_data  <= r_pf;
                  r_rd_last  <= r_pf_valid & r_pf_last;
               end
               if (w_rd_en) begin
                  r_rd_ptr   <= r_rd_ptr + ONE_L;
                  r_pf_valid <= 1'b1;
                  r_pf_last  <= ((r_rd_ptr + ONE_L) == r_frame_len);
               end else if (w_pf_take) begin
                  r_pf_valid <= 1'b0;
               end
            end
         end
      end
   end

   assign rd_valid    = r_rd_valid;
   assign rd_data     = r_rd_data;
   assign rd_last     = r_rd_last;
   assign frame_len   = r_frame_len;
   assign overflow    = r_overflow;
   assign wr_drop     = r_wr_drop;
   assign busy        = (r_state == S_CAPTURE) || (r_state == S_REPLAY);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rc4_cipher_buffer.sv
// Bench for rc4_cipher_buffer: table of frame captures with hand-derived
// expected length/overflow, hand sequences for flush, reset, drop and
// backpressure, and randomized frames checked against a queue model.
module tb_rc4_cipher_buffer;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = $clog2(DEPTH);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_HOLD    = 2'd2;
   localparam logic [1:0] ST_REPLAY  = 2'd3;

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              rd_start;
   logic              rd_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic [ADDR_W:0]   frame_len;
   logic              busy;
   logic              overflow;
   logic              wr_drop;
   logic [1:0]        dbg_state;

   always #5 clk = ~clk;

   rc4_cipher_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .rd_start   (rd_start),
      .rd_ready   (rd_ready),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_last    (rd_last),
      .frame_len  (frame_len),
      .busy       (busy),
      .overflow   (overflow),
      .wr_drop    (wr_drop),
      .o_dbg_state(dbg_state)
   );

   // ---------------- scoreboard / model state ----------------
   int checks   = 0;
   int failures = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] cap_words[$];
   logic [DATA_W-1:0] m_frame[$];
   bit m_ovf;
   bit m_drop;

   typedef struct {
      int              n;
      logic [DATA_W-1:0] base;
      int              exp_len;
      bit              exp_ovf;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // One clock: score any transfer at this edge, then check stall stability.
   task automatic tick();
      bit                live;
      logic              pv, pr, pl;
      logic [DATA_W-1:0] pd;
      logic [DATA_W-1:0] ed;
      live = (rst === 1'b1) && (flush === 1'b0);
      pv = rd_valid; pr = rd_ready; pd = rd_data; pl = rd_last;
      if (live && pv && pr) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=0x%0h required=none", pd);
         end else begin
            ed = exp_q.pop_front();
            chk("rd_data", 32'(pd), 32'(ed));
            chk("rd_last", 32'(pl), 32'(exp_q.size() == 0));
         end
      end
      @(posedge clk);
      #1;
      if (live && pv && !pr && rst && !flush) begin
         chk("stall_valid", 32'(rd_valid), 32'd1);
         chk("stall_data",  32'(rd_data),  32'(pd));
         chk("stall_last",  32'(rd_last),  32'(pl));
      end
   endtask

   // ---------------- driver tasks ----------------
   // Capture cap_words as one contiguous burst, then end the frame.
   task automatic capture(input bit with_start);
      int n;
      n = cap_words.size();
      for (int i = 0; i < n; i++) begin
         wr_valid = 1'b1;
         wr_data  = cap_words[i];
         rd_start = with_start;
         tick();
         if (i == 0) begin
            chk("cap_state",     32'(dbg_state), 32'(ST_CAPTURE));
            chk("cap_len_zero",  32'(frame_len), 32'd0);
            chk("cap_ovf_clear", 32'(overflow),  32'd0);
            chk("cap_drop_clear",32'(wr_drop),   32'd0);
            chk("cap_busy",      32'(busy),      32'd1);
         end
      end
      wr_valid = 1'b0;
      rd_start = 1'b0;
      tick();
      m_frame.delete();
      for (int i = 0; i < n && i < DEPTH; i++) m_frame.push_back(cap_words[i]);
      m_ovf  = (n > DEPTH);
      m_drop = 1'b0;
      chk("hold_state",    32'(dbg_state), 32'(ST_HOLD));
      chk("hold_len",      32'(frame_len), 32'(m_frame.size()));
      chk("hold_overflow", 32'(overflow),  32'(m_ovf));
      chk("hold_busy",     32'(busy),      32'd0);
   endtask

   // Replay the held frame. mode 0: rd_ready=1; 1: random; 2: pattern pat
   // applied from the first valid word. drop_at: loop index for a wr_valid pulse.
   task automatic replay(input int mode, input logic [15:0] pat, input int drop_at);
      int n, cyc, first_v;
      n = m_frame.size();
      foreach (m_frame[i]) exp_q.push_back(m_frame[i]);
      rd_start = 1'b1;
      rd_ready = 1'b1;
      tick();
      rd_start = 1'b0;
      chk("rep_state", 32'(dbg_state), 32'(ST_REPLAY));
      chk("rep_busy",  32'(busy),      32'd1);
      cyc = 0;
      first_v = -1;
      while (exp_q.size() > 0 && cyc < 200) begin
         if (mode == 0)      rd_ready = 1'b1;
         else if (mode == 1) rd_ready = 1'($urandom_range(0, 1));
         else                rd_ready = (cyc < 2 || cyc - 2 > 15) ? 1'b1 : pat[cyc-2];
         wr_valid = (cyc == drop_at);
         wr_data  = 8'($urandom);
         if (cyc == drop_at) m_drop = 1'b1;
         tick();
         cyc++;
         if (first_v < 0 && rd_valid) first_v = cyc;
      end
      wr_valid = 1'b0;
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL replay_timeout actual=%0d_left required=0", exp_q.size());
         exp_q.delete();
      end
      chk("first_valid_latency", 32'(first_v), 32'd2);
      if (mode == 0) chk("throughput_cycles", 32'(cyc), 32'(n + 2));
      chk("end_valid", 32'(rd_valid),  32'd0);
      chk("end_state", 32'(dbg_state), 32'(ST_HOLD));
      chk("end_drop",  32'(wr_drop),   32'(m_drop));
      chk("end_len",   32'(frame_len), 32'(n));
   endtask

   task automatic fill_seq(input int n, input logic [DATA_W-1:0] base);
      cap_words.delete();
      for (int i = 0; i < n; i++) cap_words.push_back(base + DATA_W'(i));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
      chk({tag, "_rd_last"},   32'(rd_last),   32'd0);
      chk({tag, "_rd_data"},   32'(rd_data),   32'd0);
      chk({tag, "_frame_len"}, 32'(frame_len), 32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_overflow"},  32'(overflow),  32'd0);
      chk({tag, "_wr_drop"},   32'(wr_drop),   32'd0);
      chk({tag, "_state"},     32'(dbg_state), 32'(ST_IDLE));
   endtask

   // Safety net in case a wait somehow escapes its bound.
   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main test ----------------
   initial begin
      int cnt;
      vecs[0] = '{n: 5,  base: 8'h11, exp_len: 5, exp_ovf: 1'b0};
      vecs[1] = '{n: 1,  base: 8'hA0, exp_len: 1, exp_ovf: 1'b0};
      vecs[2] = '{n: 8,  base: 8'h30, exp_len: 8, exp_ovf: 1'b0};
      vecs[3] = '{n: 10, base: 8'h00, exp_len: 8, exp_ovf: 1'b1};
      vecs[4] = '{n: 3,  base: 8'h70, exp_len: 3, exp_ovf: 1'b0};
      vecs[5] = '{n: 2,  base: 8'hFE, exp_len: 2, exp_ovf: 1'b0};

      rst = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0;
      rd_start = 1'b0; rd_ready = 1'b0;
      tick();
      tick();
      chk_reset_outputs("reset");
      rst = 1'b1;

      // rd_start in IDLE is ignored
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      chk("idle_start_ignored", 32'(dbg_state), 32'(ST_IDLE));
      chk("idle_start_novalid", 32'(rd_valid),  32'd0);

      // Table: capture, compare against hand-derived length/overflow, full-rate replay
      for (int v = 0; v < 6; v++) begin
         fill_seq(vecs[v].n, vecs[v].base);
         capture(1'b0);
         chk("vec_len", 32'(frame_len), 32'(vecs[v].exp_len));
         chk("vec_ovf", 32'(overflow),  32'(vecs[v].exp_ovf));
         replay(0, 16'hFFFF, -1);
      end

      // Backpressure: 4-word frame, rd_ready 1,0,0,1,1,0,1 then high
      fill_seq(4, 8'h40);
      capture(1'b0);
      replay(2, 16'hFFD9, -1);

      // Repeat replay with a dropped write on the second pass
      fill_seq(3, 8'hC1);
      capture(1'b0);
      replay(0, 16'hFFFF, -1);
      replay(0, 16'hFFFF, 3);
      chk("drop_sticky", 32'(wr_drop), 32'd1);
      replay(1, 16'h0000, -1);
      chk("drop_still_set", 32'(wr_drop), 32'd1);

      // rd_start together with wr_valid in HOLD: capture wins; rd_start ignored in CAPTURE
      fill_seq(4, 8'h90);
      capture(1'b1);
      replay(1, 16'h0000, -1);

      // Flush during replay after 2 of 6 words
      fill_seq(6, 8'h60);
      capture(1'b0);
      foreach (m_frame[i]) exp_q.push_back(m_frame[i]);
      rd_start = 1'b1; rd_ready = 1'b1;
      tick();
      rd_start = 1'b0;
      cnt = 0;
      while (exp_q.size() > 4 && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("flush_pre_words_taken", 32'(exp_q.size()), 32'd4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_q.delete();
      m_frame.delete();
      chk("flush_rd_valid",  32'(rd_valid),  32'd0);
      chk("flush_frame_len", 32'(frame_len), 32'd0);
      chk("flush_state",     32'(dbg_state), 32'(ST_IDLE));
      tick();
      chk("flush_stays_idle", 32'(dbg_state), 32'(ST_IDLE));
      chk("flush_no_valid",   32'(rd_valid),  32'd0);

      // Flush beats wr_valid and rd_start in HOLD
      fill_seq(2, 8'h21);
      capture(1'b0);
      flush = 1'b1; wr_valid = 1'b1; rd_start = 1'b1; wr_data = 8'hEE;
      tick();
      flush = 1'b0; wr_valid = 1'b0; rd_start = 1'b0;
      m_frame.delete();
      chk("flush_prio_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("flush_prio_len",   32'(frame_len), 32'd0);
      chk("flush_prio_busy",  32'(busy),      32'd0);

      // Reset during CAPTURE, then a fresh capture from address 0
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1; wr_data = 8'hB0 + 8'(i);
         tick();
      end
      rst = 1'b0;
      tick();
      rst = 1'b1; wr_valid = 1'b0;
      chk_reset_outputs("midreset");
      cap_words.delete();
      cap_words.push_back(8'h5A);
      cap_words.push_back(8'hA5);
      capture(1'b0);
      replay(0, 16'hFFFF, -1);

      // Randomized frames against the queue model
      for (int it = 0; it < 25; it++) begin
         int n, reps;
         n = $urandom_range(1, DEPTH + 3);
         cap_words.delete();
         for (int i = 0; i < n; i++) cap_words.push_back(8'($urandom));
         capture(1'($urandom_range(0, 1)));
         reps = $urandom_range(1, 2);
         for (int r = 0; r < reps; r++) begin
            replay(1, 16'h0000, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rc4_cipher_buffer.md
Name: rc4_cipher_buffer

Overview:
Parametrised ciphertext frame buffer between the RC4 encrypt and decrypt cores. It captures one contiguous burst of encryptor output, holds it, and replays it to the decryptor on request under valid/ready flow control. Replay can repeat any number of times. Overflow and dropped-write conditions are reported explicitly, and the buffer can be flushed. It replaces the fixed 256x8 unchecked store and free-running replay path.

Parameters:
DATA_W, 8, width of each stored ciphertext word
DEPTH, 256, number of storage words; power of two, minimum 2
ADDR_W, $clog2(DEPTH), address width; derived, not overridden

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-low; sampled on rising clk
flush  in  1  one-cycle request to discard the frame and return to IDLE
wr_valid  in  1  encryptor output word valid; a frame is a contiguous run of wr_valid=1
wr_data  in  DATA_W  ciphertext word
rd_start  in  1  one-cycle request to replay the held frame
rd_ready  in  1  decryptor accepts rd_data this cycle
rd_valid  out  1  rd_data holds a frame word
rd_data  out  DATA_W  replayed ciphertext word
rd_last  out  1  qualifies the final word of the frame; meaningful only with rd_valid
frame_len  out  ADDR_W+1  number of words held, 0..DEPTH
busy  out  1  high in CAPTURE or REPLAY
overflow  out  1  sticky: the last capture exceeded DEPTH
wr_drop  out  1  sticky: wr_valid arrived during REPLAY

Behaviour:
- Reset (rst=0 at a clock edge) forces the following, regardless of state or handshake in progress:
  - state IDLE; rd_valid=0, rd_last=0, rd_data=0
  - frame_len=0, busy=0, overflow=0, wr_drop=0
  - write and read pointers 0
  - memory contents are not cleared
- States: IDLE, CAPTURE, HOLD, REPLAY.
- IDLE:
  - wr_valid=1 writes wr_data at address 0 and sets the write count to 1.
  - Next state is CAPTURE.
- CAPTURE:
  - Each cycle with wr_valid=1 and count<DEPTH writes at address count, then increments count.
  - With wr_valid=1 and count==DEPTH, the word is discarded and overflow is set. There is no wrap-around.
  - A cycle with wr_valid=0 ends the frame: frame_len<=count, next state HOLD.
  - frame_len reads 0 until this transition.
- HOLD:
  - rd_start=1 moves to REPLAY and resets the read pointer to 0.
  - wr_valid=1 starts a new capture exactly as IDLE does. overflow and wr_drop clear on that cycle, and the old frame is lost.
  - If rd_start and wr_valid are asserted together, the capture wins and rd_start is ignored.
- REPLAY:
  - Memory read is synchronous with one prefetch register.
  - If rd_start is sampled at edge T, rd_valid is first high after edge T+2, carrying word 0.
  - A transfer occurs on each edge with rd_valid=1 and rd_ready=1.
  - While rd_valid=1 and rd_ready=0, rd_data, rd_last and rd_valid hold stable.
  - After the first word is available, full throughput is required: one word per cycle while rd_ready stays high, with no bubbles.
  - rd_last=1 exactly with word frame_len-1.
  - On the transfer of the last word, the next state is HOLD and rd_valid=0 on the following cycle. The frame is retained for repeat replay.
  - wr_valid=1 in REPLAY is ignored and sets wr_drop.
  - rd_start in REPLAY is ignored.
- rd_start in IDLE or CAPTURE is ignored.
- flush=1 (rst inactive):
  - next state IDLE; frame_len, rd_valid, rd_last, overflow and wr_drop cleared
  - takes priority over every other input in the same cycle, including wr_valid and rd_start
  - a partially replayed frame is abandoned without rd_last
- busy is combinationally (state==CAPTURE || state==REPLAY).
- Counter rule: count and frame_len are ADDR_W+1 bits wide, so DEPTH itself is representable. Pointer arithmetic never wraps in CAPTURE.

Test Plan:
- Basic loopback: 5-word burst 0x11..0x15 with rd_ready=1 throughout → frame_len=5. rd_start at cycle T → rd_valid from T+2 for 5 consecutive cycles, data 0x11..0x15, rd_last only on 0x15, then state HOLD.
- Backpressure: 4-word frame; rd_ready toggles 1,0,0,1,1,0,1 → each word presented until accepted, order intact, no duplicates or losses, rd_last once.
- Overflow: DEPTH=8, 10-word burst 0..9 → frame_len=8, overflow=1; replay yields 0..7. A new capture from HOLD clears overflow.
- Repeat replay and wr_drop: replay a 3-word frame twice → identical output both times. wr_valid pulse during the second replay → wr_drop=1, stored data unchanged.
- Flush and reset mid-operation: flush during REPLAY after 2 of 6 words → rd_valid=0 next cycle, frame_len=0, state IDLE. rst=0 during CAPTURE → all outputs at reset values on the next cycle; a following capture starts at address 0.
- Boundary: 1-word frame → rd_valid and rd_last asserted on the same single word. Exactly-DEPTH frame → frame_len=DEPTH, overflow=0.
